// File: rtl/flat_capture_pkg.sv
// Shared types for the flat-buffer snapshot/readout block.
package flat_capture_pkg;

   typedef enum logic {IDLE, STREAM} capture_state_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/flat_buffer_capture.sv
// Snapshots the whole flat window on trigger, then streams it word by word over valid/ready.
// Word 0 is valid the cycle after the capture edge; a stalled consumer holds data/index steady.
module flat_buffer_capture
   import flat_capture_pkg::*;
#(
   parameter int numChannels = 16,
   parameter int bitwidth    = 8,
   parameter int depth       = 5,
   parameter int IDXW        = $clog2(numChannels*depth)
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic [bitwidth-1:0] flat_in [numChannels*depth-1:0],
   input  logic                trigger,
   input  logic                clear,
   output logic [bitwidth-1:0] out_data,
   output logic [IDXW-1:0]     out_index,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy,
   output logic                overrun,
   output logic [CNT_W-1:0]    capture_count
);

   localparam int TOTAL = numChannels*depth;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOTAL-1);

   capture_state_t      state_q, state_d;
   logic [IDXW-1:0]     idx_q, idx_d;
   logic [bitwidth-1:0] snap_q [TOTAL-1:0];
   logic                overrun_q, overrun_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                hs, at_last, accept;

   always_comb begin
      hs      = (state_q == STREAM) && out_ready;
      at_last = (idx_q == LAST_IDX);
      // A trigger landing on the final transfer starts the next window seamlessly.
      accept  = trigger && ((state_q == IDLE) || (hs && at_last));

      state_d = state_q;
      idx_d   = idx_q;
      if (accept) begin
         state_d = STREAM;
         idx_d   = '0;
      end else if (hs) begin
         if (at_last) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IDXW'(1);
         end
      end

      overrun_d = overrun_q | (trigger && (state_q == STREAM) && !accept);
      cnt_d     = cnt_q;
      if (accept && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (clear) begin
         overrun_d = 1'b0;
         cnt_d     = accept ? CNT_W'(1) : '0;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         overrun_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         overrun_q <= overrun_d;
         cnt_q     <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < TOTAL; i++) begin
            snap_q[i] <= '0;
         end
      end else if (accept) begin
         snap_q <= flat_in;
      end
   end

   assign out_valid     = (state_q == STREAM);
   assign busy          = (state_q == STREAM);
   assign out_last      = (state_q == STREAM) && at_last;
   assign out_index     = idx_q;
   assign out_data      = snap_q[idx_q];
   assign overrun       = overrun_q;
   assign capture_count = cnt_q;

endmodule

// File: tb/tb_flat_buffer_capture.sv
// Bench for flat_buffer_capture: scoreboard of expected (index, word) pairs filled at capture time.
module tb_flat_buffer_capture;

   localparam int NCH   = 16;
   localparam int BW    = 8;
   localparam int DEP   = 5;
   localparam int TOTAL = NCH*DEP;
   localparam int IDXW  = $clog2(TOTAL);

   typedef struct {
      logic [IDXW-1:0] idx;
      logic [BW-1:0]   dat;
   } exp_t;

   logic            clk = 1'b0;
   logic            rstb = 1'b0;
   logic            trigger = 1'b0;
   logic            clear = 1'b0;
   logic            out_ready = 1'b0;
   logic [BW-1:0]   flat_in [TOTAL-1:0];
   logic [BW-1:0]   out_data;
   logic [IDXW-1:0] out_index;
   logic            out_valid, out_last, busy, overrun;
   logic [15:0]     capture_count;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   flat_buffer_capture #(.numChannels(NCH), .bitwidth(BW), .depth(DEP)) dut (
      .clk(clk), .rstb(rstb), .flat_in(flat_in), .trigger(trigger), .clear(clear),
      .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .overrun(overrun),
      .capture_count(capture_count)
   );

   task automatic push_snapshot();
      exp_t e;
      for (int k = 0; k < TOTAL; k++) begin
         e.idx = IDXW'(k);
         e.dat = flat_in[k];
         sb.push_back(e);
      end
   endtask

   task automatic do_trigger();
      @(negedge clk);
      out_ready = 1'b0;
      trigger   = 1'b1;
      push_snapshot();
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstb = 1'b0;
      out_ready = 1'b0;
      trigger = 1'b0;
      clear = 1'b0;
      sb.delete();
      @(negedge clk);
      rstb = 1'b1;
   endtask

   // Drains the scoreboard; optionally retriggers when the head reaches trig_idx.
   task automatic drain(input bit rnd, input bit scramble, input int trig_idx, output int cycles);
      logic [BW-1:0]   pd;
      logic [IDXW-1:0] pi;
      bit stalled, fired, repush;
      stalled = 1'b0; fired = 1'b0; cycles = 0; pd = '0; pi = '0;
      while (sb.size() > 0 && cycles < 4000) begin
         @(negedge clk);
         cycles++;
         trigger   = 1'b0;
         repush    = 1'b0;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (scramble) flat_in[$urandom_range(0, TOTAL-1)] = 8'($urandom);
         if (!fired && int'(sb[0].idx) == trig_idx) begin
            fired   = 1'b1;
            trigger = 1'b1;
            if (trig_idx == TOTAL-1) begin
               out_ready = 1'b1;
               for (int k = 0; k < TOTAL; k++) flat_in[k] = 8'hA5;
               repush = 1'b1;
            end
         end
         if (stalled) begin
            checks++;
            if (out_data !== pd || out_index !== pi) begin
               errors++;
               $display("FAIL stall_hold: got idx %0d data %h, need idx %0d data %h", out_index, out_data, pi, pd);
            end
         end
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_hold: out_valid %b, need 1 (head idx %0d)", out_valid, sb[0].idx);
         end
         checks++;
         if (out_last !== (sb[0].idx == IDXW'(TOTAL-1))) begin
            errors++;
            $display("FAIL out_last: got %b at head idx %0d", out_last, sb[0].idx);
         end
         if (out_ready) begin
            checks++;
            if (out_index !== sb[0].idx || out_data !== sb[0].dat) begin
               errors++;
               $display("FAIL word: got idx %0d data %h, need idx %0d data %h", out_index, out_data, sb[0].idx, sb[0].dat);
            end
            void'(sb.pop_front());
            if (repush) push_snapshot();
         end
         stalled = !out_ready;
         pd = out_data;
         pi = out_index;
      end
      if (cycles >= 4000) begin
         errors++;
         $display("FAIL drain_timeout: %0d words left", sb.size());
      end
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid %b busy %b last %b, need 0 0 0", out_valid, busy, out_last);
      end
      checks++;
      if (out_data !== '0 || out_index !== '0) begin
         errors++;
         $display("FAIL reset_data: data %h idx %0d, need 0 0", out_data, out_index);
      end
      checks++;
      if (overrun !== 1'b0 || capture_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_status: overrun %b count %0d, need 0 0", overrun, capture_count);
      end
      @(negedge clk);
      rstb = 1'b1;
   endtask

   task automatic test_stream();
      int cyc;
      for (int k = 0; k < TOTAL; k++) flat_in[k] = 8'(k);
      do_trigger();
      drain(1'b0, 1'b0, -1, cyc);
      checks++;
      if (cyc != TOTAL) begin
         errors++;
         $display("FAIL stream_cycles: got %0d, need %0d", cyc, TOTAL);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: busy %b valid %b, need 0 0", busy, out_valid);
      end
      checks++;
      if (capture_count !== 16'd1) begin
         errors++;
         $display("FAIL stream_count: got %0d, need 1", capture_count);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      for (int k = 0; k < TOTAL; k++) flat_in[k] = 8'($urandom);
      do_trigger();
      drain(1'b1, 1'b1, -1, cyc);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_end: busy %b, need 0", busy);
      end
   endtask

   task automatic test_overrun();
      int cyc;
      do_reset();
      for (int k = 0; k < TOTAL; k++) flat_in[k] = 8'(k) ^ 8'h3C;
      do_trigger();
      drain(1'b0, 1'b0, 10, cyc);
      @(negedge clk);
      checks++;
      if (overrun !== 1'b1 || capture_count !== 16'd1) begin
         errors++;
         $display("FAIL overrun_set: overrun %b count %0d, need 1 1", overrun, capture_count);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checks++;
      if (overrun !== 1'b0 || capture_count !== 16'd0) begin
         errors++;
         $display("FAIL overrun_clear: overrun %b count %0d, need 0 0", overrun, capture_count);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      do_reset();
      for (int k = 0; k < TOTAL; k++) flat_in[k] = 8'(TOTAL - k);
      do_trigger();
      drain(1'b0, 1'b0, TOTAL-1, cyc);
      checks++;
      if (cyc != 2*TOTAL) begin
         errors++;
         $display("FAIL b2b_cycles: got %0d, need %0d", cyc, 2*TOTAL);
      end
      @(negedge clk);
      checks++;
      if (overrun !== 1'b0 || capture_count !== 16'd2) begin
         errors++;
         $display("FAIL b2b_status: overrun %b count %0d, need 0 2", overrun, capture_count);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      do_reset();
      for (int k = 0; k < TOTAL; k++) flat_in[k] = 8'(k) + 8'h40;
      do_trigger();
      out_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (out_index == IDXW'(40)) break;
         @(negedge clk);
      end
      checks++;
      if (out_index !== IDXW'(40)) begin
         errors++;
         $display("FAIL mid_reach: idx %0d, need 40", out_index);
      end
      #1 rstb = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
          out_index !== '0 || overrun !== 1'b0 || capture_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: valid %b busy %b last %b data %h idx %0d ovr %b cnt %0d, need all 0",
                  out_valid, busy, out_last, out_data, out_index, overrun, capture_count);
      end
      sb.delete();
      @(negedge clk);
      rstb = 1'b1;
      for (int k = 0; k < TOTAL; k++) flat_in[k] = 8'($urandom);
      do_trigger();
      drain(1'b0, 1'b0, -1, cyc);
      checks++;
      if (cyc != TOTAL) begin
         errors++;
         $display("FAIL mid_restream: cycles %0d, need %0d", cyc, TOTAL);
      end
   endtask

   task automatic test_saturation();
      int cyc;
      do_reset();
      force dut.cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.cnt_q;
      for (int pass = 0; pass < 2; pass++) begin
         do_trigger();
         drain(1'b0, 1'b0, -1, cyc);
         @(negedge clk);
         checks++;
         if (capture_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate_%0d: got %h, need ffff", pass, capture_count);
         end
      end
      // clear coincident with an accepted trigger leaves the count at one
      clear = 1'b1;
      trigger = 1'b1;
      out_ready = 1'b0;
      push_snapshot();
      @(negedge clk);
      clear = 1'b0;
      trigger = 1'b0;
      checks++;
      if (capture_count !== 16'd1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL clear_trigger: count %0d overrun %b, need 1 0", capture_count, overrun);
      end
      drain(1'b0, 1'b0, -1, cyc);
   endtask

   initial begin
      for (int k = 0; k < TOTAL; k++) flat_in[k] = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flat_buffer_capture.md
# flat_buffer_capture

Downstream consumer of the flat sample buffer. On a trigger it takes a single-cycle snapshot of the entire flattened window (numChannels*depth words). It then streams the words out one per accepted transfer over a valid/ready interface. It sits between the datapath buffer and the debug/JTAG readout, so that slow readout logic sees a coherent window without stalling the datapath.

## Interface
Parameters:
- numChannels, 16, channels per flat-buffer row
- bitwidth, 8, bits per word
- depth, 5, buffer depth in rows; TOTAL = numChannels*depth words per snapshot
- IDXW, $clog2(numChannels*depth), index width (derived, not overridden)

Ports:
- clk  input  1  single clock
- rstb  input  1  asynchronous, active-low reset
- flat_in  input  bitwidth x [TOTAL-1:0] (unpacked)  flattened window from the flat buffer
- trigger  input  1  request a snapshot; sampled on rising clk
- clear  input  1  synchronous clear of overrun and capture_count
- out_data  output  bitwidth  current word
- out_index  output  IDXW  flat index of out_data
- out_valid  output  1  out_data/out_index valid
- out_ready  input  1  consumer accepts when out_valid & out_ready
- out_last  output  1  high while out_index == TOTAL-1 and out_valid
- busy  output  1  snapshot being streamed
- overrun  output  1  sticky: trigger arrived while busy and was dropped
- capture_count  output  16  number of accepted triggers, saturating at 16'hFFFF

## Operation
- States: IDLE, STREAM.
- IDLE: trigger=1 at an edge copies all of flat_in into the snapshot register and sets idx=0. The same edge moves the FSM to STREAM and increments capture_count (saturating).
- STREAM: out_valid=1, out_data=snap[idx], out_index=idx.
  - On valid&ready with idx<TOTAL-1: idx increments.
  - On valid&ready with idx==TOTAL-1: the FSM returns to IDLE.
  - No handshake: idx, the data and the snapshot hold.
- Trigger in STREAM, not on the final transfer: the trigger is dropped, the snapshot is untouched, and overrun is set.
- Trigger on the same edge as the final transfer: treated as a new capture. The snapshot is reloaded, idx=0, the FSM stays in STREAM, capture_count increments, and overrun is not set.
- clear: overrun=0 and capture_count=0 on the next edge. If clear and trigger coincide, the clear wins for overrun. capture_count becomes 1 if that trigger is accepted, otherwise 0.
- Ordering: words leave in ascending flat index, 0 through TOTAL-1, exactly as presented on flat_in at the capture edge.
- busy = (state == STREAM).
- Reset, asynchronous, any state:
  - state=IDLE, idx=0, out_valid=0, out_last=0, busy=0, overrun=0, capture_count=0.
  - out_data=0, out_index=0. The snapshot register is zeroed.
  - A stream in progress is abandoned, with no partial completion.

## Timing
- Capture latency: trigger sampled high at edge N gives out_valid=1 with word 0 from edge N (registered), visible during cycle N+1.
- Throughput: one word per cycle while out_ready is held high. A full snapshot drains in TOTAL cycles; 80 cycles at the defaults.
- out_valid must not drop without a handshake. out_data and out_index are stable while out_valid=1 and out_ready=0.
- out_last, busy and out_valid are derived from registered state only; there are no combinational paths from out_ready to outputs.
- Back-to-back captures: the minimum trigger-to-trigger spacing for no overrun is TOTAL cycles with out_ready held high.
- Snapshot register: TOTAL*bitwidth flops with enable = capture; no other write path.

## Structure
- Package flat_capture_pkg holds:
  - typedef enum logic {IDLE, STREAM} capture_state_t
  - localparam CNT_W = 16
- Single module. The snapshot register and the output mux live inline. The index counter with its last-detection is small enough to stay inline; no sub-module is required.

## Test plan
- Reset then trigger: flat_in[k]=k with out_ready=1. Words 0..79 emerge on consecutive cycles with out_index=k. out_last is high only at k=79, and busy falls after it. capture_count=1.
- Backpressure: toggle out_ready randomly during a stream. Every index appears exactly once in order, and data stays stable while stalled. flat_in changes mid-stream do not alter the output.
- Overrun: trigger again at index 10. The stream continues with original data, overrun=1, capture_count=1. Pulsing clear gives overrun=0 and capture_count=0.
- Trigger coincident with the final handshake, with flat_in changed to 8'hA5 everywhere. The next cycle shows index 0 with 8'hA5, overrun=0, capture_count=2.
- rstb asserted at index 40 mid-stream. All outputs are 0 immediately. After release, a new trigger streams from index 0.
- capture_count saturation: force 65535 accepted triggers, then one more. The count stays at 16'hFFFF.
